// File: rtl/fifo_write_pointer_controller.sv
// Write-side pointer controller for the async FIFO (source clock domain).
// Holds the binary write pointer and drives the registered Gray write pointer
// toward the read domain. It also produces the RAM write address, the write
// strobe and the registered full flag.
// Optional build macro FIFO_ALMOST_FULL_EN adds the registered almost_full
// output together with its read-pointer decode and occupancy logic.
module fifo_write_pointer_controller #(
  parameter int ADDRESS_WIDTH      = 3,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH:0]   synchronous_read_pointer,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic                     write_accepted,
  output logic [ADDRESS_WIDTH:0]   gray_write_pointer,
  output logic                     full
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                     almost_full
`endif
);

  localparam int P = ADDRESS_WIDTH + 1;

  logic [P-1:0] bin_q, bin_d;
  logic [P-1:0] gray_q, gray_d;
  logic [P-1:0] full_match;
  logic         full_q, full_d;

  // Accept, advance the pointer and evaluate full against the synchronized read pointer.
  // The full pattern is the read pointer with its top two Gray bits inverted.
  always_comb begin
    write_accepted = write_enable & ~full_q;
    bin_d          = bin_q + {{(P-1){1'b0}}, write_accepted};
    gray_d         = bin_d ^ (bin_d >> 1);
    full_match     = {~synchronous_read_pointer[P-1:P-2], synchronous_read_pointer[P-3:0]};
    full_d         = (gray_d == full_match);
  end

  // Pointer and flag registers; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      full_q <= full_d;
    end
  end

  assign write_address      = bin_q[ADDRESS_WIDTH-1:0];
  assign gray_write_pointer = gray_q;
  assign full               = full_q;

`ifdef FIFO_ALMOST_FULL_EN
  localparam int           DEPTH     = 1 << ADDRESS_WIDTH;
  localparam logic [P-1:0] AF_THRESH = P'(DEPTH - ALMOST_FULL_MARGIN);

  logic [P-1:0] read_bin;
  logic [P-1:0] occupancy;
  logic         almost_full_q, almost_full_d;

  // Gray-to-binary decode of the read pointer: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    read_bin = '0;
    for (int i = 0; i < P; i++) begin
      read_bin[i] = ^(synchronous_read_pointer >> i);
    end
    occupancy     = bin_d - read_bin;
    almost_full_d = (occupancy >= AF_THRESH) | full_d;
  end

  // Registered almost_full, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_write_pointer_controller.sv
module tb_fifo_write_pointer_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_enable;
  logic [3:0] synchronous_read_pointer;
  logic [2:0] write_address;
  logic       write_accepted;
  logic [3:0] gray_write_pointer;
  logic       full;
`ifdef FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  fifo_write_pointer_controller #(.ADDRESS_WIDTH(3), .ALMOST_FULL_MARGIN(2)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .write_enable             (write_enable),
    .synchronous_read_pointer (synchronous_read_pointer),
    .write_address            (write_address),
    .write_accepted           (write_accepted),
    .gray_write_pointer       (gray_write_pointer),
    .full                     (full)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    .almost_full              (almost_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] rp;
    logic       acc;
    logic [3:0] gray;
    logic [2:0] addr;
    logic       full;
    logic       af;
  } vec_t;

  typedef struct {
    logic [3:0] gray;
    logic [2:0] addr;
    logic       full;
    logic       af;
    string      tag;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check the combinational strobe, push the
  // expected post-edge state, then pop and compare just after the edge.
  task automatic cycle(input logic rst, input logic we, input logic [3:0] rp,
                       input logic chk_acc, input logic eacc,
                       input logic [3:0] eg, input logic [2:0] ea,
                       input logic ef, input logic eaf, input string tag);
    exp_t e;
    @(negedge clk);
    reset                    = rst;
    write_enable             = we;
    synchronous_read_pointer = rp;
    #1;
    if (chk_acc) chk({tag, " write_accepted"}, 32'(write_accepted), 32'(eacc));
    sb.push_back('{eg, ea, ef, eaf, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, " gray"}, 32'(gray_write_pointer), 32'(e.gray));
    chk({e.tag, " addr"}, 32'(write_address), 32'(e.addr));
    chk({e.tag, " full"}, 32'(full), 32'(e.full));
`ifdef FIFO_ALMOST_FULL_EN
    chk({e.tag, " almost_full"}, 32'(almost_full), 32'(e.af));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_g;
    int         w;
    int         rd;

    //          we    rp     acc   gray   addr  full  af
    vecs[0]  = '{1'b1, 4'h0, 1'b1, 4'b0001, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 1'b1, 4'b0011, 3'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 1'b1, 4'b0010, 3'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 1'b1, 4'b0110, 3'd4, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 1'b1, 4'b0111, 3'd5, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 1'b1, 4'b0101, 3'd6, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'h0, 1'b1, 4'b0100, 3'd7, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 1'b1, 4'b1100, 3'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 4'h0, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'h0, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'h1, 1'b0, 4'b1100, 3'd0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 4'h1, 1'b1, 4'b1101, 3'd1, 1'b1, 1'b1};

    reset = 1'b1;
    write_enable = 1'b1;
    synchronous_read_pointer = 4'h0;

    // Reset with write_enable high: nothing is written.
    cycle(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, "reset0");
    cycle(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, "reset1");

    // Fill to full, writes while full, read advance, refill.
    foreach (vecs[i]) begin
      cycle(1'b0, vecs[i].we, vecs[i].rp, 1'b1, vecs[i].acc, vecs[i].gray,
            vecs[i].addr, vecs[i].full, vecs[i].af, $sformatf("vec%0d", i));
    end

    // Mid-operation reset from the full state.
    cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, "midreset");

    // Wrap-around with the read pointer trailing four writes behind.
    w = 0;
    prev_g = 4'h0;
    for (int k = 0; k < 20; k++) begin
      rd = (w >= 4) ? (w - 4) : 0;
      cycle(1'b0, 1'b1, to_gray(rd), 1'b1, 1'b1, to_gray(w + 1), 3'((w + 1) % 8),
            1'b0, 1'b0, $sformatf("wrap%0d", k));
      chk($sformatf("wrap%0d onebit", k), 32'($countones(prev_g ^ gray_write_pointer)), 32'd1);
      prev_g = gray_write_pointer;
      w++;
    end

    // Idle cycle holds the pointer; then a final reset clears it.
    cycle(1'b0, 1'b0, to_gray(w - 4), 1'b1, 1'b0, to_gray(w), 3'(w % 8),
          1'b0, 1'b0, "idle");
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, "endreset");

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
